node_eject_receiver: RTL and testbench
======================================

NODE_EJECT_RECEIVER -- requirements
Module: node_eject_receiver

Interface
REQ-001 SHALL have parameter NODE_IP, default 3'b000, the 3-bit address of the attached node.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, the number of buffered packets; a power of 2 from 2 to 16.
REQ-003 SHALL have port shiftInCLK, input, 1 bit: the single clock, with all state on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port shiftInCS, input, 1 bit: packet-valid strobe, driven by the node's shiftOutCS.
REQ-006 SHALL have port shiftInData, input, 32 bits: packet, driven by the node's shiftOutData.
REQ-007 SHALL have port readEn, input, 1 bit: consumer pop request.
REQ-008 SHALL have port dataOut, output, 32 bits: head-of-FIFO packet (first-word-fall-through).
REQ-009 SHALL have port dataValid, output, 1 bit: FIFO non-empty.
REQ-010 SHALL have port fifoFull, output, 1 bit: FIFO holds FIFO_DEPTH packets.
REQ-011 SHALL have port pktCount, output, 16 bits: packets accepted into the FIFO.
REQ-012 SHALL have port dropCount, output, 8 bits: packets lost to overflow.
REQ-013 SHALL have port misrouteCount, output, 8 bits: packets whose destination is not NODE_IP.
REQ-014 SHALL have port misrouteFlag, output, 1 bit: sticky flag, set after any misroute.

Function
REQ-015 Packet format SHALL be: bits [31:29] destination address, bits [28:0] opaque payload.
REQ-016 A packet SHALL be sampled on each rising edge where shiftInCS=1; each CS-high cycle is one distinct packet, back-to-back cycles included.
REQ-017 Packet classification SHALL follow this priority:
  - (a) misroute if shiftInData[31:29] != NODE_IP;
  - (b) otherwise, drop if the FIFO is full and no pop occurs in the same cycle;
  - (c) otherwise, accept.
REQ-018 Accept SHALL write shiftInData at the tail pointer, advance the tail (wraps modulo FIFO_DEPTH) and increment pktCount; pktCount wraps 16'hFFFF->0.
REQ-019 Drop SHALL leave the FIFO unchanged and increment dropCount, saturating at 8'hFF.
REQ-020 Misroute SHALL leave the FIFO unchanged, increment misrouteCount (saturating at 8'hFF) and set misrouteFlag, which stays 1 until reset.
REQ-021 A pop SHALL occur when readEn=1 and dataValid=1; it advances the head pointer (wraps modulo FIFO_DEPTH).
REQ-022 readEn=1 with the FIFO empty SHALL be ignored: no pointer change, no error.
REQ-023 Simultaneous accept and pop SHALL leave the occupancy unchanged.
  - This applies when full: the incoming packet is accepted, not dropped.
  - This does not apply when empty: the pop is ignored and occupancy becomes 1.
REQ-024 Latency: a packet accepted at edge N SHALL be visible on dataOut, with dataValid=1, from immediately after edge N when the FIFO was empty.
REQ-025 Order SHALL be strict FIFO order; dataOut SHALL reflect the head entry combinationally from the registered storage.
REQ-026 When dataValid=0, dataOut SHALL be 32'h0.
REQ-027 fifoFull SHALL be 1 exactly when occupancy == FIFO_DEPTH; dataValid SHALL be 1 exactly when occupancy > 0.
REQ-028 The occupancy counter SHALL be log2(FIFO_DEPTH)+1 bits wide and SHALL never exceed FIFO_DEPTH.

Reset
REQ-029 reset=1 at a rising edge SHALL clear the head pointer, tail pointer, occupancy, pktCount, dropCount, misrouteCount and misrouteFlag; dataValid=0, fifoFull=0, dataOut=32'h0 after that edge.
REQ-030 reset SHALL take priority over a simultaneous shiftInCS or readEn; a packet presented in a reset cycle is discarded and not counted.
REQ-031 Reset asserted mid-operation SHALL flush all buffered packets; storage contents need not be cleared.

Verification
REQ-032 Single accept: NODE_IP=3'b000; one CS cycle with 32'h1092_4924 -> next cycle dataValid=1, dataOut=32'h1092_4924, pktCount=1; readEn one cycle -> dataValid=0.
REQ-033 Misroute: NODE_IP=3'b000; CS with 32'h3092_4924 (destination 001) -> misrouteFlag=1, misrouteCount=1, dataValid=0, pktCount=0.
REQ-034 Overflow: 5 back-to-back CS cycles with destination 000, no reads -> fifoFull=1, pktCount=4, dropCount=1; 4 pops return packets 1-4 in order.
REQ-035 Full with simultaneous pop: FIFO full, CS plus readEn in the same cycle -> dropCount unchanged, pktCount+1, fifoFull stays 1, new packet emerges last.
REQ-036 Saturation and wrap: 300 misroutes -> misrouteCount=8'hFF; 65537 accepted-and-popped packets -> pktCount=1.
REQ-037 Reset mid-run: 3 packets buffered, misrouteFlag=1; reset with CS=1 in the same cycle -> all outputs zero, the CS packet is not counted.

Source files
------------

// File: rtl/node_eject_receiver.sv
// Ejection-port receiver: classifies packets arriving from the attached node,
// buffers locally-addressed ones in a first-word-fall-through FIFO and keeps traffic statistics.
module node_eject_receiver #(
   parameter logic [2:0]  NODE_IP    = 3'b000,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        shiftInCLK,
   input  logic        reset,
   input  logic        shiftInCS,
   input  logic [31:0] shiftInData,
   input  logic        readEn,
   output logic [31:0] dataOut,
   output logic        dataValid,
   output logic        fifoFull,
   output logic [15:0] pktCount,
   output logic [7:0]  dropCount,
   output logic [7:0]  misrouteCount,
   output logic        misrouteFlag
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned OccW = PtrW + 1;

   logic [31:0]     storage [FIFO_DEPTH];
   logic [PtrW-1:0] headQ, headD, tailQ, tailD;
   logic [OccW-1:0] occQ, occD;
   logic [15:0]     pktCountQ, pktCountD;
   logic [7:0]      dropCountQ, dropCountD;
   logic [7:0]      misrouteCountQ, misrouteCountD;
   logic            misrouteFlagQ, misrouteFlagD;

   logic isMine, popEn, acceptEn, dropEn, misrouteEn;

   assign dataValid = (occQ != '0);
   assign fifoFull  = (occQ == OccW'(FIFO_DEPTH));

   // A pop in the same cycle frees a slot, so a full FIFO still accepts.
   always_comb begin
      isMine     = (shiftInData[31:29] == NODE_IP);
      popEn      = readEn && dataValid;
      misrouteEn = shiftInCS && !isMine;
      acceptEn   = shiftInCS && isMine && (!fifoFull || popEn);
      dropEn     = shiftInCS && isMine && fifoFull && !popEn;
   end

   always_comb begin
      headD          = headQ;
      tailD          = tailQ;
      occD           = occQ;
      pktCountD      = pktCountQ;
      dropCountD     = dropCountQ;
      misrouteCountD = misrouteCountQ;
      misrouteFlagD  = misrouteFlagQ;

      if (popEn) begin
         headD = headQ + PtrW'(1);
      end
      if (acceptEn) begin
         tailD     = tailQ + PtrW'(1);
         pktCountD = pktCountQ + 16'd1;
      end
      unique case ({acceptEn, popEn})
         2'b10:   occD = occQ + OccW'(1);
         2'b01:   occD = occQ - OccW'(1);
         default: occD = occQ;
      endcase
      if (dropEn && (dropCountQ != 8'hFF)) begin
         dropCountD = dropCountQ + 8'd1;
      end
      if (misrouteEn) begin
         misrouteFlagD = 1'b1;
         if (misrouteCountQ != 8'hFF) begin
            misrouteCountD = misrouteCountQ + 8'd1;
         end
      end
   end

   always_ff @(posedge shiftInCLK) begin
      if (reset) begin
         headQ          <= '0;
         tailQ          <= '0;
         occQ           <= '0;
         pktCountQ      <= '0;
         dropCountQ     <= '0;
         misrouteCountQ <= '0;
         misrouteFlagQ  <= 1'b0;
      end else begin
         headQ          <= headD;
         tailQ          <= tailD;
         occQ           <= occD;
         pktCountQ      <= pktCountD;
         dropCountQ     <= dropCountD;
         misrouteCountQ <= misrouteCountD;
         misrouteFlagQ  <= misrouteFlagD;
      end
   end

   // Storage is not reset; the pointers and occupancy alone define what is valid.
   always_ff @(posedge shiftInCLK) begin
      if (!reset && acceptEn) begin
         storage[tailQ] <= shiftInData;
      end
   end

   assign dataOut       = dataValid ? storage[headQ] : 32'h0;
   assign pktCount      = pktCountQ;
   assign dropCount     = dropCountQ;
   assign misrouteCount = misrouteCountQ;
   assign misrouteFlag  = misrouteFlagQ;

endmodule

// File: tb/tb_node_eject_receiver.sv
// Bench for node_eject_receiver: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_node_eject_receiver;

   localparam logic [2:0]  TbIp    = 3'b000;
   localparam int unsigned TbDepth = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        shiftInCS;
   logic [31:0] shiftInData;
   logic        readEn;
   logic [31:0] dataOut;
   logic        dataValid;
   logic        fifoFull;
   logic [15:0] pktCount;
   logic [7:0]  dropCount;
   logic [7:0]  misrouteCount;
   logic        misrouteFlag;

   node_eject_receiver #(
      .NODE_IP    (TbIp),
      .FIFO_DEPTH (TbDepth)
   ) dut (
      .shiftInCLK    (clk),
      .reset         (reset),
      .shiftInCS     (shiftInCS),
      .shiftInData   (shiftInData),
      .readEn        (readEn),
      .dataOut       (dataOut),
      .dataValid     (dataValid),
      .fifoFull      (fifoFull),
      .pktCount      (pktCount),
      .dropCount     (dropCount),
      .misrouteCount (misrouteCount),
      .misrouteFlag  (misrouteFlag)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit checking = 1'b0;

   // Reference model: plain queue and unbounded integer counters.
   logic [31:0] mq[$];
   int mPkt, mDrop, mMis;
   bit mFlag;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic modelStep(input logic cs, input logic [31:0] d, input logic rd, input logic rst);
      bit pop;
      if (rst) begin
         mq.delete();
         mPkt = 0; mDrop = 0; mMis = 0; mFlag = 1'b0;
         return;
      end
      pop = rd && (mq.size() > 0);
      if (pop) void'(mq.pop_front());
      if (cs) begin
         if (d[31:29] != TbIp) begin
            mMis++;
            mFlag = 1'b1;
         end else if ((mq.size() == TbDepth) && !pop) begin
            mDrop++;
         end else begin
            mq.push_back(d);
            mPkt++;
         end
      end
   endtask

   task automatic cyc(input logic cs, input logic [31:0] d, input logic rd, input logic rst);
      shiftInCS = cs; shiftInData = d; readEn = rd; reset = rst;
      @(posedge clk);
      modelStep(cs, d, rd, rst);
      #1;
   endtask

   always @(negedge clk) begin
      if (checking) begin
         chk("dataValid", 32'(dataValid), 32'(mq.size() > 0));
         chk("fifoFull", 32'(fifoFull), 32'(mq.size() == TbDepth));
         chk("dataOut", dataOut, (mq.size() > 0) ? mq[0] : 32'h0);
         chk("pktCount", 32'(pktCount), 32'(mPkt % 65536));
         chk("dropCount", 32'(dropCount), 32'((mDrop > 255) ? 255 : mDrop));
         chk("misrouteCount", 32'(misrouteCount), 32'((mMis > 255) ? 255 : mMis));
         chk("misrouteFlag", 32'(misrouteFlag), 32'(mFlag));
      end
   end

   initial begin
      cyc(1'b0, 32'h0, 1'b0, 1'b1);
      cyc(1'b0, 32'h0, 1'b0, 1'b1);
      checking = 1'b1;
      chk("lit reset valid", 32'(dataValid), 32'd0);
      chk("lit reset pkt", 32'(pktCount), 32'd0);
      chk("lit reset out", dataOut, 32'h0);

      // Single accept then pop.
      cyc(1'b1, 32'h1092_4924, 1'b0, 1'b0);
      chk("lit single valid", 32'(dataValid), 32'd1);
      chk("lit single out", dataOut, 32'h1092_4924);
      chk("lit single pkt", 32'(pktCount), 32'd1);
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      chk("lit single popped", 32'(dataValid), 32'd0);
      cyc(1'b0, 32'h0, 1'b1, 1'b0);  // read on empty is ignored

      // Misroute.
      cyc(1'b0, 32'h0, 1'b0, 1'b1);
      cyc(1'b1, 32'h3092_4924, 1'b0, 1'b0);
      chk("lit mis flag", 32'(misrouteFlag), 32'd1);
      chk("lit mis count", 32'(misrouteCount), 32'd1);
      chk("lit mis valid", 32'(dataValid), 32'd0);
      chk("lit mis pkt", 32'(pktCount), 32'd0);

      // Overflow: five back-to-back packets, no reads.
      cyc(1'b0, 32'h0, 1'b0, 1'b1);
      for (int i = 1; i <= 5; i++) cyc(1'b1, 32'(i), 1'b0, 1'b0);
      chk("lit ovf full", 32'(fifoFull), 32'd1);
      chk("lit ovf pkt", 32'(pktCount), 32'd4);
      chk("lit ovf drop", 32'(dropCount), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         chk("lit ovf order", dataOut, 32'(i));
         cyc(1'b0, 32'h0, 1'b1, 1'b0);
      end
      chk("lit ovf drained", 32'(dataValid), 32'd0);

      // Full with simultaneous push and pop.
      cyc(1'b0, 32'h0, 1'b0, 1'b1);
      for (int i = 1; i <= 4; i++) cyc(1'b1, 32'h10 + 32'(i), 1'b0, 1'b0);
      cyc(1'b1, 32'h15, 1'b1, 1'b0);
      chk("lit fullpop drop", 32'(dropCount), 32'd0);
      chk("lit fullpop pkt", 32'(pktCount), 32'd5);
      chk("lit fullpop full", 32'(fifoFull), 32'd1);
      for (int i = 2; i <= 5; i++) begin
         chk("lit fullpop order", dataOut, 32'h10 + 32'(i));
         cyc(1'b0, 32'h0, 1'b1, 1'b0);
      end

      // Empty with simultaneous push and pop: pop ignored.
      cyc(1'b1, 32'h77, 1'b1, 1'b0);
      chk("lit emptypop out", dataOut, 32'h77);
      cyc(1'b0, 32'h0, 1'b1, 1'b0);

      // Reset mid-run with a packet presented in the reset cycle.
      cyc(1'b0, 32'h0, 1'b0, 1'b1);
      for (int i = 1; i <= 3; i++) cyc(1'b1, 32'h0000_0A00 + 32'(i), 1'b0, 1'b0);
      cyc(1'b1, 32'hE000_0001, 1'b0, 1'b0);
      cyc(1'b1, 32'h0000_0099, 1'b0, 1'b1);
      chk("lit rst valid", 32'(dataValid), 32'd0);
      chk("lit rst out", dataOut, 32'h0);
      chk("lit rst pkt", 32'(pktCount), 32'd0);
      chk("lit rst flag", 32'(misrouteFlag), 32'd0);
      chk("lit rst mis", 32'(misrouteCount), 32'd0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0);
      chk("lit rst after pkt", 32'(pktCount), 32'd0);

      // Saturation of misroute and drop counters, then pktCount wrap.
      for (int i = 0; i < 300; i++) cyc(1'b1, 32'h4000_0000 + 32'(i), 1'b0, 1'b0);
      chk("lit mis sat", 32'(misrouteCount), 32'hFF);
      for (int i = 0; i < 264; i++) cyc(1'b1, 32'(i), 1'b0, 1'b0);
      chk("lit drop sat", 32'(dropCount), 32'hFF);
      chk("lit drop pkt", 32'(pktCount), 32'd4);
      cyc(1'b0, 32'h0, 1'b0, 1'b1);
      for (int i = 0; i < 65537; i++) cyc(1'b1, {3'b000, 29'(i)}, 1'b1, 1'b0);
      chk("lit wrap pkt", 32'(pktCount), 32'd1);
      chk("lit wrap out", dataOut, 32'd65536);
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0);

      checking = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
